// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM state encoding and
// instruction field positions.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_LDI = 4'd4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_A = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam int FIELD_W = 4;
    localparam int IMM_W   = 8;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_LDI;
    endfunction

endpackage

// File: rtl/alu_sequencer_reg_file.sv
// 16x16 register file: two operand read ports, one debug read port, one
// synchronous write port; R0 is hardwired to zero.
module reg_file_16x16 #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rs_addr,
    output logic [WIDTH-1:0] rs_data,
    input  logic [3:0]       rt_addr,
    output logic [WIDTH-1:0] rt_data,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             we,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs_data  = (rs_addr  == '0) ? '0 : regs_q[rs_addr];
    assign rt_data  = (rt_addr  == '0) ? '0 : regs_q[rt_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Control stage feeding a registered-A / accumulator ALU: fetches operands,
// drives the ALU over LOAD_A and EXEC, and writes the result back in WB.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_addsub,
    output logic             alu_xor,
    input  logic [WIDTH-1:0] alu_out,
    output logic             done,
    output logic             illegal,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    import alu_sequencer_pkg::*;

    logic [1:0]       state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [3:0]       op, rd, rs, rt, new_op;
    logic [IMM_W-1:0] imm8;
    logic [WIDTH-1:0] rs_data, rt_data, wr_data;
    logic             we;

    assign op     = instr_q[OP_LSB +: FIELD_W];
    assign rd     = instr_q[RD_LSB +: FIELD_W];
    assign rs     = instr_q[RS_LSB +: FIELD_W];
    assign rt     = instr_q[RT_LSB +: FIELD_W];
    assign imm8   = instr_q[0 +: IMM_W];
    assign new_op = instr[OP_LSB +: FIELD_W];

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = is_alu_op(new_op) ? S_LOAD_A : S_WB;
                end
            end
            S_LOAD_A: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // ALU inputs are valid only in the state where the ALU samples them.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_addsub = 1'b0;
        alu_xor    = 1'b0;
        if (state_q == S_LOAD_A) begin
            alu_a = rs_data;
        end
        if (state_q == S_EXEC) begin
            alu_b      = rt_data;
            alu_addsub = (op == OP_SUB);
            alu_xor    = (op == OP_XOR);
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_WB);
    assign illegal     = done && !is_legal_op(op);
    assign we          = done && (is_alu_op(op) || (op == OP_LDI));
    assign wr_data     = (op == OP_LDI) ? {{(WIDTH-IMM_W){1'b0}}, imm8} : alu_out;

    reg_file_16x16 #(
        .WIDTH(WIDTH),
        .NREGS(NREGS)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs),
        .rs_data  (rs_data),
        .rt_addr  (rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (we),
        .wr_addr  (rd),
        .wr_data  (wr_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered-A /
// accumulator ALU attached.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        alu_addsub, alu_xor;
    logic        done, illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(16), .NREGS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_addsub  (alu_addsub),
        .alu_xor     (alu_xor),
        .alu_out     (alu_out),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // ALU: A is registered every edge, the accumulator every edge from A_q and b.
    logic [15:0] alu_a_q, acc_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q <= '0;
            acc_q   <= '0;
        end else begin
            alu_a_q <= alu_a;
            acc_q   <= alu_xor ? (alu_a_q ^ alu_b)
                     : alu_addsub ? (alu_a_q - alu_b) : (alu_a_q + alu_b);
        end
    end
    assign alu_out = acc_q;

    typedef struct {
        logic [15:0] ins;
        int          lat;
        logic        ill;
        logic [3:0]  reg_idx;
        logic [15:0] reg_val;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        esub;
        logic        exor;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] r, input logic [15:0] v);
        dbg_addr = r;
        #1;
        chk($sformatf("dbg R%0d", r), {48'h0, dbg_data}, {48'h0, v});
    endtask

    task automatic issue(input vec_t v, input string tag);
        int   cyc;
        bit   seen;
        logic ill_at_done;
        @(negedge clk);
        chk({tag, " ready_idle"}, {63'h0, instr_ready}, 64'd1);
        chk({tag, " done_idle"}, {63'h0, done}, 64'd0);
        instr       = v.ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        cyc         = 0;
        seen        = 1'b0;
        ill_at_done = 1'b0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            chk($sformatf("%s ready_busy c%0d", tag, cyc), {63'h0, instr_ready}, 64'd0);
            if (v.lat == 3 && cyc == 1)
                chk({tag, " load_a drive"}, {30'h0, alu_a, alu_b, alu_addsub, alu_xor},
                    {30'h0, v.ea, 16'h0, 2'b00});
            else if (v.lat == 3 && cyc == 2)
                chk({tag, " exec drive"}, {30'h0, alu_a, alu_b, alu_addsub, alu_xor},
                    {30'h0, 16'h0, v.eb, v.esub, v.exor});
            else
                chk($sformatf("%s idle drive c%0d", tag, cyc),
                    {30'h0, alu_a, alu_b, alu_addsub, alu_xor}, 64'h0);
            if (done) begin
                seen        = 1'b1;
                ill_at_done = illegal;
            end else begin
                chk($sformatf("%s illegal_early c%0d", tag, cyc), {63'h0, illegal}, 64'd0);
            end
        end
        chk({tag, " latency"}, 64'(cyc), 64'(v.lat));
        chk({tag, " illegal"}, {63'h0, ill_at_done}, {63'h0, v.ill});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //            ins       lat ill  reg    value     ea        eb        sub   xor
        vecs[0] = '{16'h4112, 1, 1'b0, 4'd1, 16'h0012, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h4205, 1, 1'b0, 4'd2, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{16'h2312, 3, 1'b0, 4'd3, 16'h000D, 16'h0012, 16'h0005, 1'b1, 1'b0};
        vecs[3] = '{16'h2421, 3, 1'b0, 4'd4, 16'hFFF3, 16'h0005, 16'h0012, 1'b1, 1'b0};
        vecs[4] = '{16'h1544, 3, 1'b0, 4'd5, 16'hFFE6, 16'hFFF3, 16'hFFF3, 1'b0, 1'b0};
        vecs[5] = '{16'h3612, 3, 1'b0, 4'd6, 16'h0017, 16'h0012, 16'h0005, 1'b0, 1'b1};
        vecs[6] = '{16'h40AA, 1, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{16'h1701, 3, 1'b0, 4'd7, 16'h0012, 16'h0000, 16'h0012, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 1, 1'b0, 4'd7, 16'h0012, 16'h0000, 16'h0000, 1'b0, 1'b0};

        rst         = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        dbg_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset outputs", {44'h0, instr_ready, done, illegal, alu_addsub, alu_xor},
            {44'h0, 5'b10000});
        chk("reset alu_a/b", {32'h0, alu_a, alu_b}, 64'h0);
        chk_reg(4'd1, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
            chk_reg(vecs[i].reg_idx, vecs[i].reg_val);
        end

        // Illegal opcode with instr_valid held high through WB.
        @(negedge clk);
        instr       = 16'hF123;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ill done", {62'h0, done, illegal}, 64'd3);
        chk("ill ready_wb", {63'h0, instr_ready}, 64'd0);
        @(negedge clk);
        chk("ill back_idle", {62'h0, instr_ready, done}, 64'd2);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("ill single_consume", {62'h0, instr_ready, done}, 64'd2);
        chk_reg(4'd1, 16'h0012);
        chk_reg(4'd3, 16'h000D);

        // ADD R6,R1,R1 aborted by reset during EXEC.
        @(negedge clk);
        instr       = 16'h1611;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort load_a", {48'h0, alu_a}, 64'h0012);
        @(negedge clk);
        chk("abort exec", {47'h0, alu_b, alu_addsub}, {47'h0, 16'h0012, 1'b0});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort idle", {62'h0, instr_ready, done}, 64'd2);
        chk("abort drive", {30'h0, alu_a, alu_b, alu_addsub, alu_xor}, 64'h0);
        for (int r = 0; r < 16; r++) chk_reg(r[3:0], 16'h0000);
        repeat (3) begin
            @(negedge clk);
            chk("abort no_done", {63'h0, done}, 64'd0);
        end

        v = '{16'h493C, 1, 1'b0, 4'd9, 16'h003C, 16'h0000, 16'h0000, 1'b0, 1'b0};
        issue(v, "post_reset");
        @(negedge clk);
        chk_reg(4'd9, 16'h003C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
